uart_tx_scheduler: RTL and testbench
====================================

# uart_tx_scheduler

Transmit-side controller for the UART serial line. It arbitrates round-robin among `NUM_REQ` byte requesters and serializes the winning byte onto the single `tx` pin. Each frame is start, LSB-first data, optional parity, then stop bits. It sits between the agent-side byte producers and the `tx` pin of the UART interface, which loops `tx` back to `rx`.

## Interface
- `NUM_REQ`, 4: number of requesters; must be ≥1.
- `DATA_WIDTH`, 8: data bits per frame, 5..9.
- `BAUD_DIV`, 16: clock cycles per serial bit; must be ≥2.
- `PARITY_EN`, 1: 1 appends a parity bit.
- `PARITY_ODD`, 0: 0 selects even parity, 1 selects odd.
- `STOP_BITS`, 1: number of stop bits, 1 or 2.
- `clk`  in  1  system clock; everything is rising-edge.
- `reset`  in  1  asynchronous, active-high reset.
- `req_valid`  in  NUM_REQ  per-requester byte-available flag.
- `req_data`  in  NUM_REQ*DATA_WIDTH  requester i's byte is in slice [i*DATA_WIDTH +: DATA_WIDTH].
- `req_ready`  out  NUM_REQ  one-hot acceptance strobe.
- `tx`  out  1  serial line; idles high.
- `busy`  out  1  high while a frame is on the line.
- `grant_id`  out  max(1,$clog2(NUM_REQ))  index of the last accepted requester.

## Operation
- FSM states: IDLE, START, DATA, PARITY, STOP.
  - IDLE→START on accept.
  - START→DATA after BAUD_DIV cycles.
  - DATA→PARITY after DATA_WIDTH bits if PARITY_EN, otherwise DATA→STOP.
  - PARITY→STOP after one bit.
  - STOP→IDLE after STOP_BITS bits.
- Arbitration happens in IDLE only. Search for the first i with `req_valid[i]`, starting at pointer `rr_ptr` and wrapping modulo NUM_REQ.
- `req_ready[i]` is asserted combinationally in IDLE for the winner only.
- A transfer occurs when `req_valid[i] & req_ready[i]`. On that edge:
  - the byte is latched;
  - `grant_id` becomes i;
  - `rr_ptr` becomes (i+1) mod NUM_REQ.
- Requesters hold `req_valid` and `req_data` stable until accepted. Withdrawing `req_valid` before acceptance is legal; that request is simply not served.
- `req_ready` is 0 in every non-IDLE state.
- Baud counter: counts 0..BAUD_DIV-1 within each bit and advances to the next bit on terminal count.
- Bit index counter: 0..DATA_WIDTH-1 during DATA; reused for the stop-bit count.
- `tx` value per state:
  - START: 0.
  - DATA bit k: data[k].
  - PARITY: XOR-reduce(data) ^ PARITY_ODD.
  - STOP and IDLE: 1.
- `busy` is 1 in START, DATA, PARITY and STOP; 0 in IDLE.
- `tx` is registered, so it is glitch-free.

## Timing
- Reset values: `tx`=1, `busy`=0, `req_ready`=0, `grant_id`=0, `rr_ptr`=0, state IDLE.
- Reset asserted mid-frame: all of the above takes effect immediately, independent of `clk`. The frame is abandoned and the byte is lost.
- Accept edge T:
  - `tx` falls to 0 for cycles T+1..T+BAUD_DIV.
  - Data bit k is driven in cycles T+1+BAUD_DIV*(1+k) onward, for BAUD_DIV cycles.
- Frame length F = BAUD_DIV*(1+DATA_WIDTH+PARITY_EN+STOP_BITS) cycles.
  - The FSM re-enters IDLE at T+F+1, where the next accept can happen.
  - Back-to-back accept spacing is F+1 cycles: the last stop bit plus one idle cycle of high `tx`.
- Simultaneous requests: exactly one grant per IDLE cycle, in round-robin order.
- With a single continuously-valid requester, it is granted every F+1 cycles.

## Structure
- `UartGlobalPkg` gains:
  - typedef `uartTxStateE` (IDLE/START/DATA/PARITY/STOP);
  - constants for the default baud divider and data width.
- Natural sub-module `uart_tx_serializer`, containing the FSM, baud counter and bit counter.
  - Inputs: `load` and `data`.
  - Outputs: `tx` and `busy`.
- The arbiter (round-robin pointer, grant and ready logic) stays in `uart_tx_scheduler`.

## Test plan
- Reset: drive reset for 3 cycles with random valids, then release → `tx`=1, `busy`=0, `req_ready`=0, `grant_id`=0 throughout.
- Single request, defaults (F=176): `req_valid[0]`=1 with data 0xA5 → one `req_ready[0]` pulse. Line sampled mid-bit reads 0, 1,0,1,0,0,1,0,1, parity 0, stop 1. `busy` is high for 176 cycles.
- All four requesters valid at once, data 0x11/0x22/0x33/0x44 → grants 0,1,2,3 on accepts spaced 177 cycles apart. The rx loopback decodes 0x11,0x22,0x33,0x44.
- Fairness: `req_valid[0]` and `req_valid[2]` held high for 6 frames → `grant_id` sequence 0,2,0,2,0,2; requesters 1 and 3 never get `req_ready`.
- Reset mid-frame: assert reset at cycle 50 after accept → `tx`=1 and `busy`=0 without waiting for a clock edge. After release, requester 0 (still valid) is re-accepted with `rr_ptr`=0.
- Config PARITY_ODD=1, STOP_BITS=2, data 0x00 → parity bit 1, stop held high for 32 cycles, F=192.

Source files
------------

// File: rtl/uart_tx_scheduler_pkg.sv
// Shared UART definitions: transmit FSM state encoding and default framing constants.
package UartGlobalPkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } uartTxStateE;

    localparam int UART_DEFAULT_BAUD_DIV   = 16;
    localparam int UART_DEFAULT_DATA_WIDTH = 8;

endpackage

// File: rtl/uart_tx_serializer.sv
// Frame serializer: shifts one latched byte out as start, LSB-first data, optional parity, stop bits.
module uart_tx_serializer
    import UartGlobalPkg::*;
#(
    parameter int DATA_WIDTH = UART_DEFAULT_DATA_WIDTH,
    parameter int BAUD_DIV   = UART_DEFAULT_BAUD_DIV,
    parameter int PARITY_EN  = 1,
    parameter int PARITY_ODD = 0,
    parameter int STOP_BITS  = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  load,
    input  logic [DATA_WIDTH-1:0] data,
    output logic                  tx,
    output logic                  busy
);

    localparam int CNT_W = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
    localparam int BIT_W = 4;
    localparam int IDX_W = $clog2(DATA_WIDTH);
    localparam logic [CNT_W-1:0] BAUD_LAST = CNT_W'(BAUD_DIV - 1);
    localparam logic [BIT_W-1:0] DATA_LAST = BIT_W'(DATA_WIDTH - 1);
    localparam logic [BIT_W-1:0] STOP_LAST = BIT_W'(STOP_BITS - 1);

    uartTxStateE           state_q, state_d;
    logic [CNT_W-1:0]      baud_q, baud_d;
    logic [BIT_W-1:0]      bit_q, bit_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic                  tx_q, tx_d;
    logic                  busy_q, busy_d;
    logic                  bitEnd;

    assign bitEnd = (baud_q == BAUD_LAST);

    // tx and busy are derived from the next state so the registered line matches the state exactly.
    always_comb begin
        state_d = state_q;
        baud_d  = baud_q;
        bit_d   = bit_q;
        data_d  = data_q;
        case (state_q)
            IDLE: begin
                if (load) begin
                    state_d = START;
                    baud_d  = '0;
                    bit_d   = '0;
                    data_d  = data;
                end
            end
            START: begin
                if (bitEnd) begin
                    state_d = DATA;
                    baud_d  = '0;
                    bit_d   = '0;
                end else begin
                    baud_d = baud_q + CNT_W'(1);
                end
            end
            DATA: begin
                if (bitEnd) begin
                    baud_d = '0;
                    if (bit_q == DATA_LAST) begin
                        bit_d   = '0;
                        state_d = (PARITY_EN != 0) ? PARITY : STOP;
                    end else begin
                        bit_d = bit_q + BIT_W'(1);
                    end
                end else begin
                    baud_d = baud_q + CNT_W'(1);
                end
            end
            PARITY: begin
                if (bitEnd) begin
                    state_d = STOP;
                    baud_d  = '0;
                    bit_d   = '0;
                end else begin
                    baud_d = baud_q + CNT_W'(1);
                end
            end
            STOP: begin
                if (bitEnd) begin
                    baud_d = '0;
                    if (bit_q == STOP_LAST) begin
                        bit_d   = '0;
                        state_d = IDLE;
                    end else begin
                        bit_d = bit_q + BIT_W'(1);
                    end
                end else begin
                    baud_d = baud_q + CNT_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase

        case (state_d)
            START:   tx_d = 1'b0;
            DATA:    tx_d = data_d[bit_d[IDX_W-1:0]];
            PARITY:  tx_d = (^data_d) ^ (PARITY_ODD != 0);
            default: tx_d = 1'b1;
        endcase
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            baud_q  <= '0;
            bit_q   <= '0;
            data_q  <= '0;
            tx_q    <= 1'b1;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            data_q  <= data_d;
            tx_q    <= tx_d;
            busy_q  <= busy_d;
        end
    end

    assign tx   = tx_q;
    assign busy = busy_q;

endmodule

// File: rtl/uart_tx_scheduler.sv
// Round-robin arbiter over NUM_REQ byte requesters feeding a single UART frame serializer.
module uart_tx_scheduler
    import UartGlobalPkg::*;
#(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = UART_DEFAULT_DATA_WIDTH,
    parameter int BAUD_DIV   = UART_DEFAULT_BAUD_DIV,
    parameter int PARITY_EN  = 1,
    parameter int PARITY_ODD = 0,
    parameter int STOP_BITS  = 1,
    localparam int ID_W      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    output logic [NUM_REQ-1:0]            req_ready,
    output logic                          tx,
    output logic                          busy,
    output logic [ID_W-1:0]               grant_id
);

    logic [ID_W-1:0]       rr_ptr_q, rr_ptr_d;
    logic [ID_W-1:0]       grant_q, grant_d;
    logic [ID_W-1:0]       winner;
    logic                  found;
    logic                  accept;
    logic                  serBusy;
    logic [DATA_WIDTH-1:0] selData;

    // Scan from the round-robin pointer, wrapping, and take the first valid requester.
    always_comb begin
        int idx;
        found  = 1'b0;
        winner = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = (int'(rr_ptr_q) + k) % NUM_REQ;
            if (!found && req_valid[idx]) begin
                found  = 1'b1;
                winner = ID_W'(idx);
            end
        end
    end

    // Ready is held low during reset so a requester can never see a handshake while the line is forced idle.
    assign req_ready = (!serBusy && found && !reset) ? (NUM_REQ'(1) << winner) : '0;
    assign accept    = |(req_valid & req_ready);
    assign selData   = req_data[int'(winner)*DATA_WIDTH +: DATA_WIDTH];

    always_comb begin
        rr_ptr_d = rr_ptr_q;
        grant_d  = grant_q;
        if (accept) begin
            grant_d  = winner;
            rr_ptr_d = ID_W'((int'(winner) + 1) % NUM_REQ);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rr_ptr_q <= '0;
            grant_q  <= '0;
        end else begin
            rr_ptr_q <= rr_ptr_d;
            grant_q  <= grant_d;
        end
    end

    uart_tx_serializer #(
        .DATA_WIDTH (DATA_WIDTH),
        .BAUD_DIV   (BAUD_DIV),
        .PARITY_EN  (PARITY_EN),
        .PARITY_ODD (PARITY_ODD),
        .STOP_BITS  (STOP_BITS)
    ) uSerializer (
        .clk   (clk),
        .reset (reset),
        .load  (accept),
        .data  (selData),
        .tx    (tx),
        .busy  (serBusy)
    );

    assign busy     = serBusy;
    assign grant_id = grant_q;

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Directed self-checking bench for uart_tx_scheduler: default framing plus an odd-parity, two-stop-bit instance.
module tb_uart_tx_scheduler;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  reqValid;
    logic [31:0] reqData;
    logic [3:0]  reqReady;
    logic        txLine;
    logic        busy;
    logic [1:0]  grantId;

    logic [3:0]  reqValidCfg;
    logic [31:0] reqDataCfg;
    logic [3:0]  reqReadyCfg;
    logic        txCfg;
    logic        busyCfg;
    logic [1:0]  grantCfg;

    int checks = 0;
    int errors = 0;
    int cycleCount = 0;

    logic [7:0] rxBytes[$];
    logic [7:0] rxByte;
    bit         rxActive;
    int         rxCnt;
    int         rxBit;

    bit monitorOdd = 1'b0;
    int oddReadySeen = 0;

    always #5 clk = ~clk;

    always @(posedge clk) cycleCount++;

    uart_tx_scheduler #(
        .NUM_REQ(4), .DATA_WIDTH(8), .BAUD_DIV(16),
        .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(1)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (reqValid),
        .req_data  (reqData),
        .req_ready (reqReady),
        .tx        (txLine),
        .busy      (busy),
        .grant_id  (grantId)
    );

    uart_tx_scheduler #(
        .NUM_REQ(4), .DATA_WIDTH(8), .BAUD_DIV(16),
        .PARITY_EN(1), .PARITY_ODD(1), .STOP_BITS(2)
    ) dutCfg (
        .clk       (clk),
        .reset     (reset),
        .req_valid (reqValidCfg),
        .req_data  (reqDataCfg),
        .req_ready (reqReadyCfg),
        .tx        (txCfg),
        .busy      (busyCfg),
        .grant_id  (grantCfg)
    );

    // Loopback receiver on the default instance: mid-bit sampling after a detected start edge.
    always @(negedge clk) begin
        if (reset) begin
            rxActive = 1'b0;
            rxCnt    = 0;
        end else if (!rxActive) begin
            if (txLine === 1'b0) begin
                rxActive = 1'b1;
                rxCnt    = 1;
            end
        end else begin
            rxCnt++;
            if (rxCnt >= 9 && ((rxCnt - 9) % 16) == 0) begin
                rxBit = (rxCnt - 9) / 16;
                if (rxBit >= 1 && rxBit <= 8) rxByte[rxBit-1] = txLine;
                if (rxBit == 10) begin
                    rxBytes.push_back(rxByte);
                    rxActive = 1'b0;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (monitorOdd && (reqReady[1] || reqReady[3])) oddReadySeen++;
    end

    task automatic doReset();
        @(negedge clk);
        reset       = 1'b1;
        reqValid    = 4'b0;
        reqValidCfg = 4'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic waitForReady(input bit useCfg, input int budget, output int who, output bit ok);
        logic [3:0] vec;
        ok  = 1'b0;
        who = -1;
        for (int n = 0; n < budget && !ok; n++) begin
            #1;
            vec = useCfg ? reqReadyCfg : reqReady;
            if (vec != 4'b0) begin
                ok = 1'b1;
                for (int i = 0; i < 4; i++) if (vec[i]) who = i;
            end else begin
                @(negedge clk);
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        for (int n = 0; n < 3; n++) begin
            @(negedge clk);
            reqValid    = 4'($urandom);
            reqValidCfg = 4'($urandom);
            #1;
            checks++;
            if (txLine !== 1'b1 || busy !== 1'b0 || reqReady !== 4'b0 || grantId !== 2'd0) begin
                errors++;
                $display("[TB] FAIL reset_hold: tx=%b busy=%b ready=%b grant=%0d, want tx=1 busy=0 ready=0000 grant=0",
                         txLine, busy, reqReady, grantId);
            end
        end
        @(negedge clk);
        reqValid    = 4'b0;
        reqValidCfg = 4'b0;
        reset       = 1'b0;
        for (int n = 0; n < 2; n++) begin
            @(negedge clk);
            checks++;
            if (txLine !== 1'b1 || busy !== 1'b0 || reqReady !== 4'b0 || grantId !== 2'd0) begin
                errors++;
                $display("[TB] FAIL reset_release: tx=%b busy=%b ready=%b grant=%0d, want tx=1 busy=0 ready=0000 grant=0",
                         txLine, busy, reqReady, grantId);
            end
        end
    endtask

    task automatic test_single();
        int who;
        bit ok;
        int busyCount = 0;
        int readyDuring = 0;
        logic [10:0] expBits = {1'b1, 1'b0, 8'hA5, 1'b0};
        doReset();
        reqData  = 32'h0000_00A5;
        reqValid = 4'b0001;
        waitForReady(1'b0, 20, who, ok);
        checks++;
        if (!ok || reqReady !== 4'b0001) begin
            errors++;
            $display("[TB] FAIL single_ready: ready=%b ok=%0d, want 0001", reqReady, ok);
        end
        if (!ok) return;
        @(posedge clk);
        @(negedge clk);
        reqValid = 4'b0;
        for (int c = 1; c <= 180; c++) begin
            if (c > 1) @(negedge clk);
            if (busy === 1'b1) busyCount++;
            if (c <= 176 && reqReady !== 4'b0) readyDuring++;
            if (c >= 9 && ((c - 9) % 16) == 0 && ((c - 9) / 16) < 11) begin
                checks++;
                if (txLine !== expBits[(c-9)/16]) begin
                    errors++;
                    $display("[TB] FAIL single_bit%0d: tx=%b, want %b", (c - 9) / 16, txLine, expBits[(c-9)/16]);
                end
            end
            if (c == 177) begin
                checks++;
                if (busy !== 1'b0 || txLine !== 1'b1) begin
                    errors++;
                    $display("[TB] FAIL single_idle_after: busy=%b tx=%b, want busy=0 tx=1", busy, txLine);
                end
            end
        end
        checks++;
        if (busyCount != 176) begin
            errors++;
            $display("[TB] FAIL single_busy_len: %0d cycles, want 176", busyCount);
        end
        checks++;
        if (readyDuring != 0) begin
            errors++;
            $display("[TB] FAIL single_ready_busy: ready seen %0d cycles during frame, want 0", readyDuring);
        end
    endtask

    task automatic test_all_four();
        int who;
        bit ok;
        int acceptCycle;
        int prevAccept = 0;
        doReset();
        rxBytes.delete();
        reqData  = 32'h4433_2211;
        reqValid = 4'b1111;
        for (int k = 0; k < 4; k++) begin
            waitForReady(1'b0, 400, who, ok);
            if (!ok) begin
                checks++;
                errors++;
                $display("[TB] FAIL all4_timeout: no ready for grant %0d, want ready within 400 cycles", k);
                break;
            end
            checks++;
            if (who != k) begin
                errors++;
                $display("[TB] FAIL all4_winner%0d: got %0d, want %0d", k, who, k);
            end
            @(posedge clk);
            @(negedge clk);
            acceptCycle = cycleCount;
            if (who >= 0) reqValid[who] = 1'b0;
            checks++;
            if (grantId !== 2'(k)) begin
                errors++;
                $display("[TB] FAIL all4_grant%0d: grant_id=%0d, want %0d", k, grantId, k);
            end
            if (k > 0) begin
                checks++;
                if (acceptCycle - prevAccept != 177) begin
                    errors++;
                    $display("[TB] FAIL all4_spacing%0d: %0d cycles, want 177", k, acceptCycle - prevAccept);
                end
            end
            prevAccept = acceptCycle;
        end
        reqValid = 4'b0;
        repeat (200) @(negedge clk);
        checks++;
        if (rxBytes.size() != 4) begin
            errors++;
            $display("[TB] FAIL all4_rx_count: %0d bytes, want 4", rxBytes.size());
        end
        for (int i = 0; i < rxBytes.size() && i < 4; i++) begin
            checks++;
            if (rxBytes[i] !== 8'((i + 1) * 17)) begin
                errors++;
                $display("[TB] FAIL all4_rx%0d: 0x%02h, want 0x%02h", i, rxBytes[i], 8'((i + 1) * 17));
            end
        end
    endtask

    task automatic test_fairness();
        int who;
        bit ok;
        doReset();
        reqData      = 32'h00CC_00AA;
        reqValid     = 4'b0101;
        oddReadySeen = 0;
        monitorOdd   = 1'b1;
        for (int k = 0; k < 6; k++) begin
            waitForReady(1'b0, 400, who, ok);
            if (!ok) begin
                checks++;
                errors++;
                $display("[TB] FAIL fair_timeout: no ready for frame %0d, want ready within 400 cycles", k);
                break;
            end
            @(posedge clk);
            @(negedge clk);
            checks++;
            if (grantId !== 2'((k % 2) * 2)) begin
                errors++;
                $display("[TB] FAIL fair_grant%0d: grant_id=%0d, want %0d", k, grantId, (k % 2) * 2);
            end
        end
        reqValid   = 4'b0;
        monitorOdd = 1'b0;
        checks++;
        if (oddReadySeen != 0) begin
            errors++;
            $display("[TB] FAIL fair_starved_ready: ready on req 1/3 seen %0d times, want 0", oddReadySeen);
        end
    endtask

    task automatic test_reset_mid_frame();
        int who;
        bit ok;
        doReset();
        reqData  = 32'h0000_5500;
        reqValid = 4'b0011;
        waitForReady(1'b0, 20, who, ok);
        checks++;
        if (!ok || who != 0) begin
            errors++;
            $display("[TB] FAIL mid_first_winner: got %0d, want 0", who);
        end
        if (!ok) return;
        @(posedge clk);
        @(negedge clk);
        repeat (49) @(negedge clk);
        checks++;
        if (busy !== 1'b1 || txLine !== 1'b0) begin
            errors++;
            $display("[TB] FAIL mid_in_frame: busy=%b tx=%b, want busy=1 tx=0", busy, txLine);
        end
        reset = 1'b1;
        #1;
        checks++;
        if (txLine !== 1'b1 || busy !== 1'b0 || reqReady !== 4'b0) begin
            errors++;
            $display("[TB] FAIL mid_async_reset: tx=%b busy=%b ready=%b, want tx=1 busy=0 ready=0000",
                     txLine, busy, reqReady);
        end
        @(negedge clk);
        reset = 1'b0;
        #1;
        checks++;
        if (reqReady !== 4'b0001 || grantId !== 2'd0) begin
            errors++;
            $display("[TB] FAIL mid_rr_cleared: ready=%b grant=%0d, want ready=0001 grant=0", reqReady, grantId);
        end
        @(posedge clk);
        @(negedge clk);
        checks++;
        if (busy !== 1'b1 || grantId !== 2'd0) begin
            errors++;
            $display("[TB] FAIL mid_reaccept: busy=%b grant=%0d, want busy=1 grant=0", busy, grantId);
        end
        reqValid = 4'b0;
    endtask

    task automatic test_config();
        int who;
        bit ok;
        int busyCount = 0;
        int stopHigh = 0;
        logic [11:0] expBits = 12'hE00;
        doReset();
        reqDataCfg  = 32'h0;
        reqValidCfg = 4'b0001;
        waitForReady(1'b1, 20, who, ok);
        checks++;
        if (!ok || who != 0) begin
            errors++;
            $display("[TB] FAIL cfg_ready: got %0d, want 0", who);
        end
        if (!ok) return;
        @(posedge clk);
        @(negedge clk);
        reqValidCfg = 4'b0;
        for (int c = 1; c <= 196; c++) begin
            if (c > 1) @(negedge clk);
            if (busyCfg === 1'b1) busyCount++;
            if (c >= 161 && c <= 192 && txCfg === 1'b1) stopHigh++;
            if (c >= 9 && ((c - 9) % 16) == 0 && ((c - 9) / 16) < 12) begin
                checks++;
                if (txCfg !== expBits[(c-9)/16]) begin
                    errors++;
                    $display("[TB] FAIL cfg_bit%0d: tx=%b, want %b", (c - 9) / 16, txCfg, expBits[(c-9)/16]);
                end
            end
            if (c == 193) begin
                checks++;
                if (busyCfg !== 1'b0 || txCfg !== 1'b1) begin
                    errors++;
                    $display("[TB] FAIL cfg_idle_after: busy=%b tx=%b, want busy=0 tx=1", busyCfg, txCfg);
                end
            end
        end
        checks++;
        if (busyCount != 192) begin
            errors++;
            $display("[TB] FAIL cfg_busy_len: %0d cycles, want 192", busyCount);
        end
        checks++;
        if (stopHigh != 32) begin
            errors++;
            $display("[TB] FAIL cfg_stop_len: %0d high cycles, want 32", stopHigh);
        end
    endtask

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        reset       = 1'b1;
        reqValid    = 4'b0;
        reqData     = 32'h0;
        reqValidCfg = 4'b0;
        reqDataCfg  = 32'h0;
        test_reset();
        test_single();
        test_all_four();
        test_fairness();
        test_reset_mid_frame();
        test_config();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
